switch_event_capture: RTL and testbench
=======================================

SWITCH_EVENT_CAPTURE -- requirements
Module: switch_event_capture

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 125000 (1 ms at 125 MHz), consecutive stable samples required to accept a level change; legal range 2..2^20.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 SWITCHES  input  4  raw asynchronous switch levels.
REQ-005 sw_state  output  4  debounced switch levels.
REQ-006 evt_valid  output  1  event available at the output.
REQ-007 evt_ready  input  1  consumer accepts the event.
REQ-008 evt_id  output  2  index of the switch that produced the event.
REQ-009 evt_rise  output  1  1 = rising edge, 0 = falling edge.
REQ-010 evt_ovf  output  1  sticky flag: an event was lost.
REQ-011 ovf_clr  input  1  single-cycle pulse; clears evt_ovf.

Function
REQ-012 Each SWITCHES bit SHALL pass a 2-flop synchronizer before any other use.
REQ-013 Each bit SHALL have an independent debounce FSM: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-014 STABLE_LO -> WAIT_HI when the synchronized bit is 1; the counter loads 1.
REQ-015 WAIT_HI: synchronized 1 -> counter +1; synchronized 0 -> STABLE_LO, counter cleared.
REQ-016 WAIT_HI -> STABLE_HI when the counter equals DEBOUNCE_CYCLES and the bit is still 1; this generates a one-cycle rise pulse. STABLE_HI/WAIT_LO mirror this with polarity inverted and generate a fall pulse.
REQ-017 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); the counter SHALL never wrap.
REQ-018 sw_state[i] SHALL be 1 in STABLE_HI and WAIT_LO, and 0 otherwise.
REQ-019 Each accepted pulse SHALL set pending[i], recording the edge direction.
REQ-020 Output register: when empty, or when a transfer occurs this cycle, it loads the lowest-index pending bit and clears that bit in the same cycle.
REQ-021 evt_valid, evt_id and evt_rise SHALL hold stable until evt_valid and evt_ready are both high.
REQ-022 Latency: a clean level change held steady SHALL raise evt_valid exactly DEBOUNCE_CYCLES+3 cycles after the first clock edge that samples the new level, when the output register is idle.
REQ-023 A new pulse on a switch whose pending bit is already set SHALL overwrite the recorded direction and set evt_ovf.
REQ-024 A new pulse on switch i in the same cycle that pending[i] is loaded into the output SHALL leave pending[i] set and SHALL NOT set evt_ovf.
REQ-025 ovf_clr and a new overflow in the same cycle: evt_ovf SHALL remain 1.
REQ-026 Glitches shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no event.

Reset
REQ-027 While reset=0 at a clock edge, the block SHALL:
- put all FSMs in STABLE_LO, clear counters, synchronizers and pending bits;
- drive evt_valid=0, evt_id=0, evt_rise=1, evt_ovf=0, sw_state=0.
REQ-028 Reset mid-debounce or mid-handshake SHALL discard all in-flight events; no event SHALL be emitted for switches already high at reset release until they pass STABLE_LO->STABLE_HI debounce.

Configuration
REQ-029 Macro SWITCH_EVT_FALLING_EN defined: falling edges (REQ-016) SHALL generate events with evt_rise=0.
REQ-030 Macro absent: falling edges SHALL update sw_state only, evt_rise SHALL be constant 1, and pending direction storage SHALL be omitted.

Structure
REQ-031 Shared package: debounce state enum, NUM_SW=4 constant, ID width constant.
REQ-032 One sub-module, switch_debounce (synchronizer + FSM + counter for one bit), instantiated 4 times; arbitration and handshake SHALL live in the top.

Verification (DEBOUNCE_CYCLES=4 for simulation)
REQ-033 SWITCHES[2] 0->1, held, evt_ready=1 -> evt_valid high 7 cycles later for one cycle; evt_id=2, evt_rise=1; sw_state=0100.
REQ-034 SWITCHES[0] pulsed high for 3 cycles -> no event; sw_state stays 0000.
REQ-035 SWITCHES 0000->1001 in one cycle, evt_ready=0 for 20 cycles, then 1 -> events delivered in order id 0, then id 3, with payload stable while stalled.
REQ-036 evt_ready=0; switch 1 rises, then (with the macro) falls after debounce -> evt_ovf=1; one event is delivered with id 1, evt_rise=0; ovf_clr -> evt_ovf=0.
REQ-037 reset=0 asserted during WAIT_HI and with evt_valid=1 -> next cycle evt_valid=0, sw_state=0000; no event appears after reset release with inputs low.

Source files
------------

// File: rtl/switch_event_capture_pkg.sv
// Shared types and constants for the switch event capture block.
// Debounce state encoding, switch count and event id helpers.
package switch_event_capture_pkg;

    localparam int NUM_SW = 4;
    localparam int ID_W   = $clog2(NUM_SW);

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } deb_state_t;

    // Lowest set index wins; zero when nothing is set.
    function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_SW-1:0] v);
        lowest_set = '0;
        for (int i = NUM_SW - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = ID_W'(i);
        end
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch: 2-flop synchronizer, debounce FSM and saturating counter.
// Emits single-cycle rise/fall pulses when a new level is accepted.
module switch_debounce
    import switch_event_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 125000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_state,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          sync1;
    logic          sync2;
    deb_state_t    state;
    deb_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Bring the raw level into the clock domain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Debounce state and counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= STABLE_LO;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; counter stops at CNT_MAX, so it never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise      = 1'b0;
        fall      = 1'b0;
        unique case (state)
            STABLE_LO: begin
                if (sync2) begin
                    state_nxt = WAIT_HI;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!sync2) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                    rise      = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!sync2) begin
                    state_nxt = WAIT_LO;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (sync2) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                    fall      = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
        endcase
    end

    assign sw_state = (state == STABLE_HI) || (state == WAIT_LO);

endmodule

// File: rtl/switch_event_capture.sv
// Debounced switch events with pending flags and a valid/ready output.
// Define SWITCH_EVT_FALLING_EN to also report falling edges.
module switch_event_capture
    import switch_event_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 125000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_SW-1:0] SWITCHES,
    output logic [NUM_SW-1:0] sw_state,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [ID_W-1:0]   evt_id,
    output logic              evt_rise,
    output logic              evt_ovf,
    input  logic              ovf_clr
);

    logic [NUM_SW-1:0] rise;
    logic [NUM_SW-1:0] fall;
    logic [NUM_SW-1:0] hit;
    logic [NUM_SW-1:0] pend;
    logic [NUM_SW-1:0] pend_nxt;
    logic [NUM_SW-1:0] take_mask;
    logic [ID_W-1:0]   sel_id;
    logic              xfer;
    logic              take;
    logic              ovf_set;

    genvar g;
    generate
        for (g = 0; g < NUM_SW; g++) begin : g_deb
            switch_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk     (clk),
                .reset   (reset),
                .sw_raw  (SWITCHES[g]),
                .sw_state(sw_state[g]),
                .rise    (rise[g]),
                .fall    (fall[g])
            );
        end
    endgenerate

`ifdef SWITCH_EVT_FALLING_EN
    logic [NUM_SW-1:0] pend_dir;
    logic [NUM_SW-1:0] pend_dir_nxt;

    assign hit          = rise | fall;
    assign pend_dir_nxt = (pend_dir & ~hit) | (rise & hit);
`else
    logic unused_fall;

    assign hit         = rise;
    assign unused_fall = ^fall;
`endif

    assign sel_id = lowest_set(pend);
    assign xfer   = evt_valid & evt_ready;
    assign take   = (|pend) & (~evt_valid | xfer);

    // A pulse landing on a flag that is being taken this cycle is not lost.
    always_comb begin
        take_mask = '0;
        if (take) take_mask[sel_id] = 1'b1;
        pend_nxt = (pend & ~take_mask) | hit;
        ovf_set  = |(pend & ~take_mask & hit);
    end

    // Pending flags and sticky overflow; a new overflow beats a clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend    <= '0;
            evt_ovf <= 1'b0;
        end else begin
            pend    <= pend_nxt;
            evt_ovf <= (evt_ovf & ~ovf_clr) | ovf_set;
        end
    end

    // Output register holds its payload until accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
        end else if (take) begin
            evt_valid <= 1'b1;
            evt_id    <= sel_id;
        end else if (xfer) begin
            evt_valid <= 1'b0;
        end
    end

`ifdef SWITCH_EVT_FALLING_EN
    // Edge direction per pending flag and for the presented event.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_dir <= '0;
            evt_rise <= 1'b1;
        end else begin
            pend_dir <= pend_dir_nxt;
            if (take) evt_rise <= pend_dir[sel_id];
        end
    end
`else
    assign evt_rise = 1'b1;
`endif

endmodule

// File: tb/tb_switch_event_capture.sv
// Randomized bench for switch_event_capture against a behavioural model.
// Model: level accepted after DEBOUNCE+1 equal samples; lowest-index arbitration.
module tb_switch_event_capture;

    localparam int N = 4;
`ifdef SWITCH_EVT_FALLING_EN
    localparam logic FALL_EN = 1'b1;
`else
    localparam logic FALL_EN = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic [3:0] SWITCHES  = 4'b0;
    logic       evt_ready = 1'b0;
    logic       ovf_clr   = 1'b0;
    logic [3:0] sw_state;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_rise;
    logic       evt_ovf;

    always #5 clk = ~clk;

    switch_event_capture #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .SWITCHES (SWITCHES),
        .sw_state (sw_state),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id   (evt_id),
        .evt_rise (evt_rise),
        .evt_ovf  (evt_ovf),
        .ovf_clr  (ovf_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Inputs as seen by each rising edge.
    logic [3:0] s_sw  = 4'b0;
    logic       s_rdy = 1'b0;
    logic       s_clr = 1'b0;
    logic       s_rst = 1'b0;

    always @(posedge clk) begin
        s_sw  <= SWITCHES;
        s_rdy <= evt_ready;
        s_clr <= ovf_clr;
        s_rst <= reset;
    end

    // Behavioural model state.
    logic [3:0] m_dq[$];
    logic [N:0] m_win[4];
    logic [3:0] m_lvl   = 4'b0;
    bit         m_pend[4];
    bit         m_pdir[4];
    bit         m_valid = 1'b0;
    int         m_id    = 0;
    bit         m_rise  = 1'b1;
    bit         m_ovf   = 1'b0;

    task automatic model_step();
        logic [3:0] seen;
        bit hit[4];
        bit hdir[4];
        bit xfer;
        bit newovf;
        int pick;
        if (!s_rst) begin
            m_dq.delete();
            m_dq.push_back(4'b0);
            m_dq.push_back(4'b0);
            m_lvl   = 4'b0;
            m_valid = 1'b0;
            m_id    = 0;
            m_rise  = 1'b1;
            m_ovf   = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_win[i]  = '0;
                m_pend[i] = 1'b0;
                m_pdir[i] = 1'b0;
            end
            return;
        end
        m_dq.push_back(s_sw);
        seen = m_dq.pop_front();
        for (int i = 0; i < 4; i++) begin
            m_win[i] = {m_win[i][N-1:0], seen[i]};
            hit[i]   = 1'b0;
            hdir[i]  = 1'b1;
            if (!m_lvl[i] && (&m_win[i])) begin
                m_lvl[i] = 1'b1;
                hit[i]   = 1'b1;
            end else if (m_lvl[i] && (m_win[i] == '0)) begin
                m_lvl[i] = 1'b0;
                hit[i]   = FALL_EN;
                hdir[i]  = 1'b0;
            end
        end
        xfer = m_valid && s_rdy;
        pick = -1;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) pick = i;
        if ((!m_valid || xfer) && pick >= 0) begin
            m_valid      = 1'b1;
            m_id         = pick;
            m_rise       = FALL_EN ? m_pdir[pick] : 1'b1;
            m_pend[pick] = 1'b0;
        end else if (xfer) begin
            m_valid = 1'b0;
        end
        newovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (hit[i]) begin
                if (m_pend[i]) newovf = 1'b1;
                m_pend[i] = 1'b1;
                m_pdir[i] = hdir[i];
            end
        end
        m_ovf = (m_ovf && !s_clr) || newovf;
    endtask

    // Compare process: every cycle after the edge settles.
    initial begin
        forever begin
            @(negedge clk);
            model_step();
            chk("sw_state", 32'(sw_state), 32'(m_lvl));
            chk("evt_valid", 32'(evt_valid), 32'(m_valid));
            chk("evt_ovf", 32'(evt_ovf), 32'(m_ovf));
            if (m_valid) begin
                chk("evt_id", 32'(evt_id), 32'(m_id));
                chk("evt_rise", 32'(evt_rise), 32'(m_rise));
            end
            if (!s_rst) begin
                chk("rst_id", 32'(evt_id), 32'd0);
                chk("rst_rise", 32'(evt_rise), 32'd1);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        SWITCHES  = 4'b0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    int seen_v;
    logic [1:0] id_mid;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_sw", 32'(sw_state), 32'd0);
        chk("rst_ovf", 32'(evt_ovf), 32'd0);
        reset = 1'b1;

        // Single rise on switch 2 with the consumer ready.
        @(negedge clk);
        SWITCHES  = 4'b0100;
        evt_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("r33_sw_pre", 32'(sw_state), 32'd0);
        @(negedge clk);
        chk("r33_sw", 32'(sw_state), 32'b0100);
        chk("r33_nv", 32'(evt_valid), 32'd0);
        @(negedge clk);
        chk("r33_v", 32'(evt_valid), 32'd1);
        chk("r33_id", 32'(evt_id), 32'd2);
        chk("r33_rise", 32'(evt_rise), 32'd1);
        @(negedge clk);
        chk("r33_v_drop", 32'(evt_valid), 32'd0);

        // Three-cycle glitch on switch 0.
        SWITCHES = 4'b0101;
        repeat (3) @(negedge clk);
        SWITCHES = 4'b0100;
        seen_v = 0;
        repeat (15) begin
            @(negedge clk);
            if (evt_valid) seen_v++;
        end
        chk("r34_noevt", 32'(seen_v), 32'd0);
        chk("r34_sw", 32'(sw_state), 32'b0100);

        // Two simultaneous rises under a stall.
        do_reset();
        SWITCHES = 4'b1001;
        repeat (10) @(negedge clk);
        id_mid = evt_id;
        chk("r35_id_mid", 32'(id_mid), 32'd0);
        repeat (10) @(negedge clk);
        chk("r35_v", 32'(evt_valid), 32'd1);
        chk("r35_id_hold", 32'(evt_id), 32'(id_mid));
        evt_ready = 1'b1;
        @(negedge clk);
        chk("r35_v2", 32'(evt_valid), 32'd1);
        chk("r35_id2", 32'(evt_id), 32'd3);
        @(negedge clk);
        chk("r35_empty", 32'(evt_valid), 32'd0);

        // Overflow on switch 1 while the output is occupied.
        do_reset();
        SWITCHES = 4'b0001;
        repeat (10) @(negedge clk);
        SWITCHES = 4'b0011;
        repeat (10) @(negedge clk);
        chk("r36_noovf", 32'(evt_ovf), 32'd0);
        SWITCHES = 4'b0001;
        repeat (10) @(negedge clk);
        chk("r36_ovf", 32'(evt_ovf), 32'(FALL_EN));
        evt_ready = 1'b1;
        @(negedge clk);
        chk("r36_id", 32'(evt_id), 32'd1);
        chk("r36_rise", 32'(evt_rise), 32'(!FALL_EN));
        @(negedge clk);
        chk("r36_empty", 32'(evt_valid), 32'd0);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("r36_clr", 32'(evt_ovf), 32'd0);

        // Reset during a debounce and with an event on the output.
        do_reset();
        SWITCHES = 4'b0100;
        repeat (9) @(negedge clk);
        chk("r37_v", 32'(evt_valid), 32'd1);
        SWITCHES = 4'b0110;
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        SWITCHES = 4'b0000;
        @(negedge clk);
        chk("r37_rv", 32'(evt_valid), 32'd0);
        chk("r37_rsw", 32'(sw_state), 32'd0);
        reset  = 1'b1;
        seen_v = 0;
        repeat (20) begin
            @(negedge clk);
            if (evt_valid) seen_v++;
        end
        chk("r37_noevt", 32'(seen_v), 32'd0);

        // Random levels, stalls, clears and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 11) == 0) SWITCHES[b] = ~SWITCHES[b];
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 499) != 0);
        end
        @(negedge clk);
        reset   = 1'b1;
        ovf_clr = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
